divider_64by32_seq: RTL
=======================

DIVIDER_64BY32_SEQ -- requirements
Module: divider_64by32_seq

Interface
REQ-001 SHALL have parameter N, default 32, giving the divisor width; the dividend and quotient are 2N bits wide.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only when ready=1.
REQ-005 SHALL have port dividend  input  2N  unsigned numerator (e.g. a product from the 32x32 multiplier); sampled with start.
REQ-006 SHALL have port divisor  input  N  unsigned denominator; sampled with start.
REQ-007 SHALL have port ready  output  1  high only in IDLE.
REQ-008 SHALL have port busy  output  1  high only in RUN.
REQ-009 SHALL have port quotient  output  2N  unsigned quotient, registered.
REQ-010 SHALL have port remainder  output  N  unsigned remainder, registered.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; qualifies the current result.
REQ-012 SHALL have port valid_out  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid for the completed operation.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL act as follows in IDLE with start=1 and divisor!=0: latch dividend and divisor, clear the partial remainder (N+1 bits), load the bit counter with 2N-1, and go to RUN.
REQ-015 SHALL act as follows in IDLE with start=1 and divisor==0: set quotient to all ones, set remainder to dividend[N-1:0], set div_by_zero=1, and go to DONE without entering RUN.
REQ-016 SHALL perform one restoring step per RUN cycle: shift the next dividend bit (MSB first) into the partial remainder; subtract the divisor if the partial remainder >= divisor; shift the comparison result into the quotient LSB.
REQ-017 SHALL use N+1-bit compare/subtract width so that no partial-remainder overflow occurs.
REQ-018 SHALL leave RUN for DONE after exactly 2N RUN cycles, counter 0 being the last, with the final quotient and remainder registered on that edge.
REQ-019 SHALL remain in DONE for exactly one cycle, assert valid_out=1 there, and then return to IDLE.
REQ-020 SHALL give a latency of 2N+1 clocks from the start-accepting edge to the valid_out cycle (65 clocks for N=32), or 1 clock on divide-by-zero.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable after DONE until the next accepted start.
REQ-022 SHALL ignore start while in RUN or DONE, with no queuing and no corruption of the operation in flight.
REQ-023 SHALL ignore changes to dividend or divisor after acceptance.
REQ-024 SHALL clear div_by_zero on acceptance of a start with a non-zero divisor.
REQ-025 SHALL accept a new operation on the first IDLE cycle after DONE; back-to-back throughput is one result per 2N+2 clocks.
REQ-026 SHALL produce results satisfying quotient*divisor + remainder == dividend and remainder < divisor for every non-zero divisor.
REQ-027 SHALL use no combinational path from any input to any output.

Reset
REQ-028 SHALL, on rst_n=0, immediately and regardless of clk, set: state=IDLE, ready=1, busy=0, valid_out=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and internal registers.
REQ-029 SHALL, on reset assertion mid-RUN, abandon the operation with no valid_out pulse; after rst_n deasserts, the first start SHALL be accepted normally.
REQ-030 SHALL deassert reset safely: the first active edge after rst_n rises is a normal IDLE cycle.

Verification
REQ-031 Basic case: dividend=100, divisor=7, start for 1 cycle -> busy for 64 cycles, valid_out on clock 65, quotient=14, remainder=2, div_by_zero=0.
REQ-032 Maximum case: dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=0xFFFF_FFFF -> quotient=0x0000_0001_0000_0001, remainder=0.
REQ-033 Divide by zero: dividend=0x1234, divisor=0 -> valid_out one clock after start, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1, busy never high.
REQ-034 Start while busy: start with 5/9; at clock 10 pulse start with 50/5 -> second request ignored, single valid_out at clock 65 with quotient=0, remainder=5; ready=0 throughout.
REQ-035 Reset mid-operation: rst_n low at clock 30 of 1000/3 -> outputs zero immediately, no valid_out; a following 1000/3 -> quotient=333, remainder=1.
REQ-036 Round trip: 1000 random a,b pairs; divide a*b (64-bit) by b!=0 -> quotient=a, remainder=0; random dividend/divisor pairs satisfy REQ-026.

Source files
------------

// File: rtl/divider_64by32_if.sv
// ---------------------------------------------------------------------------
// divider_64by32_seq_if
// Handshake and data bundle for the sequential 2N-by-N unsigned divider.
//
// Signals (directions as seen from the divider, i.e. the slave modport):
//   start        in   request to begin a division, sampled only when ready=1
//   dividend     in   2N-bit unsigned numerator, sampled with start
//   divisor      in   N-bit unsigned denominator, sampled with start
//   ready        out  divider is idle and will accept start
//   busy         out  division in progress
//   quotient     out  2N-bit registered quotient
//   remainder    out  N-bit registered remainder
//   div_by_zero  out  registered flag qualifying the current result
//   valid_out    out  one-cycle pulse marking a completed operation
// ---------------------------------------------------------------------------
interface divider_64by32_seq_if #(
    parameter int N = 32
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             ready;
    logic             busy;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             valid_out;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, quotient, remainder, div_by_zero, valid_out
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, quotient, remainder, div_by_zero, valid_out
    );
endinterface

// File: rtl/divider_64by32_seq.sv
// ---------------------------------------------------------------------------
// divider_64by32_seq
// Sequential restoring divider: 2N-bit unsigned dividend by N-bit unsigned
// divisor, one quotient bit per clock (2N RUN cycles), then a single DONE
// cycle carrying the valid_out pulse. Divide-by-zero skips RUN entirely and
// returns an all-ones quotient with the low dividend bits as remainder.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of divider_64by32_seq_if (start/dividend/divisor in;
//          ready/busy/quotient/remainder/div_by_zero/valid_out out)
//
// All outputs are decoded from or held in registers; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module divider_64by32_seq #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    divider_64by32_seq_if.slave  bus
);
    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    // Dividend bits leave from the top while quotient bits enter at the
    // bottom, so after 2N steps this register holds the quotient.
    logic [2*N-1:0]  work_q;
    logic [N-1:0]    divisor_q;
    logic [N:0]      prem_q;
    logic [2*N-1:0]  quotient_q;
    logic [N-1:0]    remainder_q;
    logic            dbz_q;

    logic [N:0]      prem_shift;
    logic [N:0]      prem_diff;
    logic [N:0]      prem_next;
    logic            q_bit;
    logic [2*N-1:0]  work_next;

    // One restoring step on an N+1-bit partial remainder. The bit shifted
    // out of prem_q acts as the carry of an N+2-bit compare: if it is set,
    // the shifted value certainly exceeds the divisor.
    always_comb begin
        prem_shift = {prem_q[N-1:0], work_q[2*N-1]};
        prem_diff  = prem_shift - {1'b0, divisor_q};
        q_bit      = prem_q[N] | (prem_shift >= {1'b0, divisor_q});
        prem_next  = q_bit ? prem_diff : prem_shift;
        work_next  = {work_q[2*N-2:0], q_bit};
    end

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the datapath registers are all reset too, because the result
    // outputs must read zero during reset and the working registers are
    // required to start clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            work_q      <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[N-1:0];
                            dbz_q       <= 1'b1;
                        end else begin
                            work_q    <= bus.dividend;
                            divisor_q <= bus.divisor;
                            prem_q    <= '0;
                            cnt_q     <= CW'(2 * N - 1);
                            dbz_q     <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    work_q <= work_next;
                    prem_q <= prem_next;
                    cnt_q  <= cnt_q - CW'(1);
                    // Results are published on the last RUN edge and then
                    // held untouched until the next accepted start.
                    if (cnt_q == '0) begin
                        quotient_q  <= work_next;
                        remainder_q <= prem_next[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = (state_q == S_IDLE);
    assign bus.busy        = (state_q == S_RUN);
    assign bus.valid_out   = (state_q == S_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
